// File: rtl/ddr3_burst_sched_if.sv
// Burst handshake between the DDR3 burst scheduler and the AXI burst master.
// master = scheduler side (issues req/addr/len), slave = AXI burst master side.
interface ddr3_burst_sched_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LEN_W  = 10
);
  logic              wd_req;
  logic [ADDR_W-1:0] wd_addr;
  logic [LEN_W-1:0]  wd_len;
  logic              wd_finish;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_finish;

  modport master (
    output wd_req, wd_addr, wd_len,
    input  wd_finish,
    output rd_req, rd_addr, rd_len,
    input  rd_finish
  );

  modport slave (
    input  wd_req, wd_addr, wd_len,
    output wd_finish,
    input  rd_req, rd_addr, rd_len,
    output rd_finish
  );
endinterface

// File: rtl/ddr3_burst_sched.sv
// DDR3 write/read burst scheduler: FIFO-level arbitration, wrapping window addresses,
// read gating until a full write frame exists, and a per-burst done watchdog.
module ddr3_burst_sched #(
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned LEN_W       = 10,
  parameter int unsigned CNT_W       = 11,
  parameter int unsigned RFIFO_DEPTH = 1024,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ddr3_init_done,
  input  logic [ADDR_W-1:0] addr_wd_min,
  input  logic [ADDR_W-1:0] addr_wd_max,
  input  logic [LEN_W-1:0]  wd_burst_len,
  input  logic [ADDR_W-1:0] addr_rd_min,
  input  logic [ADDR_W-1:0] addr_rd_max,
  input  logic [LEN_W-1:0]  rd_burst_len,
  input  logic [CNT_W-1:0]  wfifo_rcount,
  input  logic [CNT_W-1:0]  rfifo_wcount,
  ddr3_burst_sched_if.master bus,
  output logic              frame_valid,
  output logic              wr_wrap,
  output logic              rd_wrap,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned SumW  = CNT_W + 1;
  localparam int unsigned AsumW = ADDR_W + 1;
  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StWrReq, StWrWait, StRdReq, StRdWait} state_e;

  state_e            state_q;
  logic              last_wr_q;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [WdogW-1:0]  wdog_q;
  logic              wd_req_q, rd_req_q;
  logic [ADDR_W-1:0] wd_addr_q, rd_addr_q;
  logic [LEN_W-1:0]  wd_len_q, rd_len_q;

  logic             wd_elig, rd_elig, wdog_hit;
  logic [SumW-1:0]  rd_fill_sum;
  logic [AsumW-1:0] wd_next, rd_next;

  always_comb begin
    rd_fill_sum = SumW'(rfifo_wcount) + SumW'(rd_burst_len);
    wd_elig     = (wd_burst_len != '0) && (SumW'(wfifo_rcount) >= SumW'(wd_burst_len));
    rd_elig     = frame_valid && (rd_burst_len != '0) && (rd_fill_sum <= SumW'(RFIFO_DEPTH));
    wd_next     = AsumW'(wd_addr_q) + AsumW'(wd_len_q);
    rd_next     = AsumW'(rd_addr_q) + AsumW'(rd_len_q);
    wdog_hit    = (wdog_q == WdogW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_wr_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wdog_q      <= '0;
      wd_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      wd_addr_q   <= '0;
      rd_addr_q   <= '0;
      wd_len_q    <= '0;
      rd_len_q    <= '0;
      frame_valid <= 1'b0;
      wr_wrap     <= 1'b0;
      rd_wrap     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wr_wrap <= 1'b0;
      rd_wrap <= 1'b0;
      if (!ddr3_init_done) begin
        // Master is held in reset alongside us; restart the frame from the window starts.
        state_q     <= StIdle;
        wd_req_q    <= 1'b0;
        rd_req_q    <= 1'b0;
        wr_ptr_q    <= addr_wd_min;
        rd_ptr_q    <= addr_rd_min;
        frame_valid <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            // Write wins unless read is also eligible and write had the last grant.
            if (wd_elig && (!rd_elig || !last_wr_q)) begin
              state_q   <= StWrReq;
              wd_req_q  <= 1'b1;
              wd_addr_q <= wr_ptr_q;
              wd_len_q  <= wd_burst_len;
              last_wr_q <= 1'b1;
            end else if (rd_elig) begin
              state_q   <= StRdReq;
              rd_req_q  <= 1'b1;
              rd_addr_q <= rd_ptr_q;
              rd_len_q  <= rd_burst_len;
              last_wr_q <= 1'b0;
            end
          end
          StWrReq: begin
            wd_req_q <= 1'b0;
            wdog_q   <= '0;
            state_q  <= StWrWait;
          end
          StWrWait: begin
            if (bus.wd_finish) begin
              if (wd_next >= AsumW'(addr_wd_max)) begin
                wr_ptr_q    <= addr_wd_min;
                wr_wrap     <= 1'b1;
                frame_valid <= 1'b1;
              end else begin
                wr_ptr_q <= wd_next[ADDR_W-1:0];
              end
              state_q <= StIdle;
            end else if (wdog_hit) begin
              timeout_err <= 1'b1;
              state_q     <= StIdle;
            end else begin
              wdog_q <= wdog_q + WdogW'(1);
            end
          end
          StRdReq: begin
            rd_req_q <= 1'b0;
            wdog_q   <= '0;
            state_q  <= StRdWait;
          end
          StRdWait: begin
            if (bus.rd_finish) begin
              if (rd_next >= AsumW'(addr_rd_max)) begin
                rd_ptr_q <= addr_rd_min;
                rd_wrap  <= 1'b1;
              end else begin
                rd_ptr_q <= rd_next[ADDR_W-1:0];
              end
              state_q <= StIdle;
            end else if (wdog_hit) begin
              timeout_err <= 1'b1;
              state_q     <= StIdle;
            end else begin
              wdog_q <= wdog_q + WdogW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.wd_req  = wd_req_q;
  assign bus.wd_addr = wd_addr_q;
  assign bus.wd_len  = wd_len_q;
  assign bus.rd_req  = rd_req_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.rd_len  = rd_len_q;
  assign busy        = (state_q != StIdle);

endmodule
